iob_cache_be_mem: RTL



---
 rtl/iob_cache_be_mem.sv | 134 +++++++++++++
 1 files changed

// File: rtl/iob_cache_be_mem.sv
// iob_cache_be_mem
// Native IOb slave memory model for the cache back-end port. Read and write
// latencies are set by parameters, so the cache miss, write-through and stall
// paths can be exercised. Saturating counters record accepted reads and writes.
//
// Ports:
//   clk_i      clock
//   arst_i     asynchronous reset, active-high
//   cke_i      clock enable; when low, every piece of state (memory too) holds
//   valid_i    request valid
//   addr_i     word address
//   wdata_i    write data
//   wstrb_i    byte write strobes; all-zero selects a read
//   rdata_o    read data, qualified by rvalid_o, held until the next response
//   rvalid_o   one-cycle read response pulse
//   ready_o    request accept
//   nreads_o   accepted reads, saturating
//   nwrites_o  accepted writes, saturating
module iob_cache_be_mem #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 0,
  parameter int CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                ready_o,
  output logic [CNT_W-1:0]    nreads_o,
  output logic [CNT_W-1:0]    nwrites_o
);

  localparam int         NB     = DATA_W / 8;
  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [7:0] RD_CNT = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_CNT = (WR_LAT == 0) ? 8'd0 : 8'(WR_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [CNT_W-1:0]   nreads_q, nwrites_q;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_word;
  logic               acc, rd_acc, wr_acc;

  // Ready also rises in the read response cycle, so a new request can be
  // accepted alongside the response (one read per cycle when RD_LAT=1).
  assign ready_o = (state_q == IDLE) || (state_q == RD_WAIT && cnt_q == 8'd0);

  assign acc     = valid_i & ready_o & cke_i;
  assign rd_acc  = acc & ~(|wstrb_i);
  assign wr_acc  = acc & (|wstrb_i);
  assign rd_word = mem[addr_i];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      RD_WAIT, WR_WAIT: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Acceptance only happens while ready_o is high, i.e. when the wait
    // state is already finishing, so a new request simply overrides it.
    if (rd_acc) begin
      state_d = RD_WAIT;
      cnt_d   = RD_CNT;
    end else if (wr_acc) begin
      state_d = (WR_LAT == 0) ? IDLE : WR_WAIT;
      cnt_d   = WR_CNT;
    end
    // The response is registered: it is raised at the edge that lands the
    // FSM on RD_WAIT with an exhausted counter. With RD_LAT=1 that is the
    // acceptance edge itself, so the word comes straight from the array.
    rvalid_d = (state_d == RD_WAIT) && (cnt_d == 8'd0);
    rdata_d  = rd_acc ? rd_word : data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      data_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      nreads_q  <= '0;
      nwrites_q <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      if (rvalid_d) rdata_q <= rdata_d;
      if (rd_acc)   data_q  <= rd_word;
      if (rd_acc && nreads_q != {CNT_W{1'b1}})
        nreads_q <= nreads_q + CNT_W'(1);
      if (wr_acc && nwrites_q != {CNT_W{1'b1}})
        nwrites_q <= nwrites_q + CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; clearing it
  // would cost a huge reset fan-out and the model must keep contents anyway.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign nreads_o  = nreads_q;
  assign nwrites_o = nwrites_q;

endmodule
